f32m_demux6: RTL
================

// Module: f32m_demux6
// PURPOSE
//  Write-back demultiplexer for GF(3^{2M}) operands: the write side of the six-way one-hot operand select.
//  Accepts one element per valid/ready transfer with a one-hot destination (l0..l5).
//  Stores the element in one of six holding registers, each with a full flag.
//  The holding registers feed the operand selectors of the pairing datapath; a consumer frees a slot with clear[i].
// PARAMETERS
//  M      97   degree of irreducible polynomial; element width 4*M bits (two GF(3^M) halves, 2 bits/digit)
//  CNT_W  8    width of accepted-transfer counter
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       producer has an element on in_data
//  in_ready   out  1       block can take in_data this cycle
//  in_data    in   4*M     GF(3^{2M}) element; [2M-1:0] low half, [4M-1:2M] high half
//  l0..l5     in   1 each  one-hot destination select
//  clear      in   6       clear[i] releases slot i (pulse)
//  v0..v5     out  4*M     holding registers
//  full       out  6       full[i]=1: v[i] holds an unconsumed element
//  err_sel    out  1       sticky: transfer attempted with illegal select
//  err_digit  out  1       sticky: accepted element contained digit code 2'b11
//  acc_cnt    out  CNT_W   count of accepted writes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): v0..v5=0, full=0, err_sel=0, err_digit=0, acc_cnt=0.
//  sel={l5..l0}; legal = exactly one bit set.
//  in_ready = legal ? ~full[k] : 1, where k is the set bit. No combinational path from clear or in_valid to in_ready.
//  Accept = in_valid & in_ready & legal, at clock edge:
//   - v[k] <= in_data; full[k] <= 1; acc_cnt <= acc_cnt+1.
//   - Outputs visible the cycle after acceptance (1-cycle latency).
//   - Other registers hold.
//  Illegal select (zero-hot or multi-hot) with in_valid=1:
//   - in_ready=1, so the transfer completes and is dropped.
//   - No register or full change; acc_cnt unchanged; err_sel <= 1.
//  Digit check: per 2-bit digit over all 2M digits. Any 2'b11 in an accepted element sets err_digit <= 1.
//   The element is still written unchanged.
//  clear[i]=1 at a clock edge: full[i] <= 0. v[i] is NOT zeroed (holds last value).
//   - clear on an empty slot: no effect.
//   - Multiple clear bits in the same cycle: all honoured.
//  Simultaneous write to slot k and clear[k]: write is not possible (in_ready=0 because full[k]=1).
//   The clear takes effect; the producer's next-cycle retry is accepted.
//  Simultaneous write to slot k and clear[j], j!=k: both take effect.
//  Producer holds in_data and sel stable while in_valid & ~in_ready. The block does not check this.
//  acc_cnt wraps 2^CNT_W-1 -> 0 silently.
//  err_sel/err_digit clear only on reset.
//  Reset mid-transfer: all state is lost; in_ready reflects post-reset empty slots immediately.
// STRUCTURE
//  Shared include/package: M, WIDTH=2M-1, W2=4M-1, ZERO, digit code constants (00=0, 01=1, 10=2, 11=illegal).
//  Sub-module f3m_digit_check (input [WIDTH:0], output bad): OR of per-digit (d[2i]&d[2i+1]).
//   Instantiated twice, once per element half.
//  Slot registers and full flags: one generate loop over six slots.
//  One-hot legality: popcount==1 on the 6 select bits.
// TESTING
//  1 Reset, then in_valid with l2=1, in_data=4M'h1 -> in_ready=1; next cycle v2=1, full=6'b000100, acc_cnt=1.
//  2 Slot 2 full, write to l2 again with in_data=4M'h2 -> in_ready=0, v2 stays 1.
//     Pulse clear[2] -> next cycle write accepted, v2=2.
//  3 sel=6'b000000 and sel=6'b010001 with in_valid -> in_ready=1, v*/full unchanged, err_sel=1, acc_cnt unchanged.
//  4 Accept in_data with digit 0 = 2'b11 (low bits 2'b11) to l0 -> v0 written as sent, err_digit=1.
//     Same test with bits [2M+1:2M]=2'b11.
//  5 Fill all six slots, then clear=6'b101010 in the same cycle as a write to l0
//     -> full=6'b010101; the l0 write stalls (slot 0 was full).
//  6 Perform 2^CNT_W+3 accepted writes with clears interleaved -> acc_cnt=3.
//     Assert reset mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/f32m_demux6_pkg.sv
// Shared constants and helpers for the GF(3^{2M}) write-back demultiplexer.
// Digits are 2-bit codes; 2'b11 is the one code that never encodes a GF(3) value.
package f32m_demux6_pkg;

  localparam int F32M_M     = 97;
  localparam int F32M_CNT_W = 8;
  localparam int NSLOT      = 6;

  localparam int WIDTH = 2 * F32M_M - 1;
  localparam int W2    = 4 * F32M_M - 1;
  localparam logic [W2:0] ZERO = '0;

  typedef enum logic [1:0] {
    DIG_0   = 2'b00,
    DIG_1   = 2'b01,
    DIG_2   = 2'b10,
    DIG_BAD = 2'b11
  } digit_e;

  function automatic logic is_onehot(input logic [NSLOT-1:0] s);
    return $countones(s) == 1;
  endfunction

endpackage

// File: rtl/f32m_demux6_digit_check.sv
// Flags any 2'b11 digit in one GF(3^M) half of an element.
// Pure combinational OR-reduction over the per-digit illegal-code detectors.
module f3m_digit_check
  import f32m_demux6_pkg::*;
#(
  parameter int HW = WIDTH
) (
  input  logic [HW:0] d,
  output logic        bad
);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < (HW + 1) / 2; i++) begin
      if ({d[2*i+1], d[2*i]} == DIG_BAD) bad = 1'b1;
    end
  end

endmodule

// File: rtl/f32m_demux6.sv
// Six-slot write-back demultiplexer: one-hot routed valid/ready writes into holding
// registers with full flags, consumer-side clear, sticky error flags and a write counter.
module f32m_demux6
  import f32m_demux6_pkg::*;
#(
  parameter int M     = F32M_M,
  parameter int CNT_W = F32M_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*M-1:0]   in_data,
  input  logic             l0,
  input  logic             l1,
  input  logic             l2,
  input  logic             l3,
  input  logic             l4,
  input  logic             l5,
  input  logic [5:0]       clear,
  output logic [4*M-1:0]   v0,
  output logic [4*M-1:0]   v1,
  output logic [4*M-1:0]   v2,
  output logic [4*M-1:0]   v3,
  output logic [4*M-1:0]   v4,
  output logic [4*M-1:0]   v5,
  output logic [5:0]       full,
  output logic             err_sel,
  output logic             err_digit,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int EW = 4 * M;
  localparam int HW = 2 * M;

  logic [NSLOT-1:0] sel;
  logic             legal;
  logic             accept;
  logic             bad_lo;
  logic             bad_hi;
  logic [EW-1:0]    v_all [NSLOT];
  logic [NSLOT-1:0] full_vec;

  assign sel   = {l5, l4, l3, l2, l1, l0};
  assign legal = is_onehot(sel);

  // in_ready depends only on select and registered full flags, never on clear or in_valid.
  assign in_ready = legal ? ~|(sel & full_vec) : 1'b1;
  assign accept   = in_valid & in_ready & legal;

  f3m_digit_check #(.HW(HW - 1)) u_chk_lo (
    .d   (in_data[HW-1:0]),
    .bad (bad_lo)
  );

  f3m_digit_check #(.HW(HW - 1)) u_chk_hi (
    .d   (in_data[EW-1:HW]),
    .bad (bad_hi)
  );

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic [EW-1:0] v_d, v_q;
    logic          full_d, full_q;

    // A write can only land on an empty slot, so it never races its own clear.
    always_comb begin
      v_d    = v_q;
      full_d = full_q;
      if (clear[i]) full_d = 1'b0;
      if (accept && sel[i]) begin
        v_d    = in_data;
        full_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q    <= '0;
        full_q <= 1'b0;
      end else begin
        v_q    <= v_d;
        full_q <= full_d;
      end
    end

    assign v_all[i]    = v_q;
    assign full_vec[i] = full_q;
  end

  logic [CNT_W-1:0] acc_cnt_d, acc_cnt_q;
  logic             err_sel_d, err_sel_q;
  logic             err_digit_d, err_digit_q;

  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    err_sel_d   = err_sel_q;
    err_digit_d = err_digit_q;
    if (accept) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
      if (bad_lo || bad_hi) err_digit_d = 1'b1;
    end
    if (in_valid && !legal) err_sel_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      err_sel_q   <= 1'b0;
      err_digit_q <= 1'b0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      err_sel_q   <= err_sel_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign v0        = v_all[0];
  assign v1        = v_all[1];
  assign v2        = v_all[2];
  assign v3        = v_all[3];
  assign v4        = v_all[4];
  assign v5        = v_all[5];
  assign full      = full_vec;
  assign err_sel   = err_sel_q;
  assign err_digit = err_digit_q;
  assign acc_cnt   = acc_cnt_q;

endmodule
